// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: sync, per-key debounce,
// press/release strobes and optional auto-repeat.
module key_debounce_multi #(
  parameter int KEY_CNT       = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_RATE   = 5000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [KEY_CNT-1:0] key_in,
  output logic [KEY_CNT-1:0] key_level,
  output logic [KEY_CNT-1:0] key_press,
  output logic [KEY_CNT-1:0] key_release,
  output logic [KEY_CNT-1:0] key_repeat,
  output logic               any_press
);

  localparam int CW   = $clog2(STABLE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [CW-1:0] C_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] D_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_RATE
  } rstate_t;

  logic [KEY_CNT-1:0] key_n;
  logic [KEY_CNT-1:0] press_c;
  logic [KEY_CNT-1:0] rel_c;

  assign key_n = ACTIVE_LOW ? ~key_in : key_in;

  for (genvar g = 0; g < KEY_CNT; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   lvl_q;
    logic                   prs_q;
    logic                   rls_q;
    logic                   hit;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], key_n[g]};
    end

    assign s          = sync[SYNC_STAGES-1];
    assign hit        = (s != lvl_q) && (cnt == C_MAX);
    assign press_c[g] = hit & s;
    assign rel_c[g]   = hit & ~s;

    // any cycle agreeing with the level restarts the count
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rls_q <= 1'b0;
      end else begin
        prs_q <= press_c[g];
        rls_q <= rel_c[g];
        if (s == lvl_q) begin
          cnt <= '0;
        end else if (cnt == C_MAX) begin
          lvl_q <= s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end

    assign key_level[g]   = lvl_q;
    assign key_press[g]   = prs_q;
    assign key_release[g] = rls_q;

    if (REPEAT_EN) begin : g_rep
      rstate_t       st, st_d;
      logic [RW-1:0] r, r_d;
      logic          rep_d, rep_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          st    <= R_IDLE;
          r     <= '0;
          rep_q <= 1'b0;
        end else begin
          st    <= st_d;
          r     <= r_d;
          rep_q <= rep_d;
        end
      end

      // release wins, so a repeat never lands on the release cycle
      always_comb begin
        st_d  = st;
        r_d   = r;
        rep_d = 1'b0;
        if (rel_c[g]) begin
          st_d = R_IDLE;
          r_d  = '0;
        end else begin
          unique case (st)
            R_IDLE: begin
              if (press_c[g]) begin
                st_d = R_DELAY;
                r_d  = '0;
              end
            end
            R_DELAY: begin
              if (r == D_MAX) begin
                rep_d = 1'b1;
                r_d   = '0;
                st_d  = R_RATE;
              end else begin
                r_d = r + RW'(1);
              end
            end
            R_RATE: begin
              if (r == R_MAX) begin
                rep_d = 1'b1;
                r_d   = '0;
              end else begin
                r_d = r + RW'(1);
              end
            end
            default: begin
              st_d = R_IDLE;
              r_d  = '0;
            end
          endcase
        end
      end

      assign key_repeat[g] = rep_q;
    end else begin : g_norep
      assign key_repeat[g] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) any_press <= 1'b0;
    else        any_press <= |press_c;
  end

endmodule
